counter_window_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit up-counter among NREQ requesters. Each requester asks for a timed window of a given length. The block grants one requester at a time, clears the shared counter, enables it until it reaches the requested terminal value, then pulses a per-requester done. It sits between the requesting logic and the shared counter and is the only driver of the counter's clear and enable.

---
 rtl/counter_window_arbiter.sv | 138 +++++++++++++
 tb/tb_counter_window_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/counter_window_arbiter.sv
// Round-robin sequencer sharing one up-counter among NREQ requesters.
// Each grant clears the counter, counts to the latched length, then pulses done.
module counter_window_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  input  logic              abort,
  input  logic [W-1:0]      cnt_q,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              aborted,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for a request; arbitration from ptr
  // CLEAR | owner granted, counter cleared
  // RUN   | counter enabled until it reaches len_lat or abort
  // DONE  | done pulse to owner, ptr advances past owner
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d, owner, owner_d, pick, cand;
  logic [IW:0]     sum;
  logic            found;
  logic [W-1:0]    len_lat, len_d;
  logic            abt, abt_d;
  logic [NREQ-1:0] gnt_d, done_d;
  logic            clr_d, en_d, aborted_d, busy_d;

  always_comb begin
    found = 1'b0;
    pick  = ptr;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    len_d   = len_lat;
    abt_d   = abt;
    ptr_d   = ptr;
    en_d    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          len_d   = len[pick*W +: W];
          abt_d   = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          abt_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RUN;
          en_d    = (len_lat != '0);
        end
      end
      RUN: begin
        if (abort) begin
          abt_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == len_lat) begin
          state_d = DONE;
        end else begin
          // cnt_en is registered, so predict the counter value it will see
          en_d = ((cnt_q + W'(cnt_en)) != len_lat);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    gnt_d     = '0;
    done_d    = '0;
    aborted_d = 1'b0;
    clr_d     = (state_d == CLEAR);
    busy_d    = (state_d != IDLE);
    if (state_d == CLEAR || state_d == RUN) gnt_d[owner_d] = 1'b1;
    if (state_d == DONE) begin
      done_d[owner_d] = 1'b1;
      aborted_d       = abt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      len_lat <= '0;
      abt     <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      cnt_clr <= 1'b0;
      cnt_en  <= 1'b0;
      aborted <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      owner   <= owner_d;
      len_lat <= len_d;
      abt     <= abt_d;
      gnt     <= gnt_d;
      done    <= done_d;
      cnt_clr <= clr_d;
      cnt_en  <= en_d;
      aborted <= aborted_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_counter_window_arbiter.sv
// Directed bench for counter_window_arbiter with a behavioural shared counter.
module tb_counter_window_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] len = '0;
  logic              abort = 1'b0;
  logic [W-1:0]      cnt_q = '0;
  logic              cnt_clr, cnt_en, aborted, busy;
  logic [NREQ-1:0]   gnt, done;

  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;

  counter_window_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len), .abort(abort),
    .cnt_q(cnt_q), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .gnt(gnt),
    .done(done), .aborted(aborted), .busy(busy)
  );

  always #5 clk = ~clk;

  // shared counter: clear wins over enable
  always @(posedge clk) begin
    if (cnt_clr) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("gnt_done_excl", 32'((|gnt) && (|done)), 32'd0);
    end
  end

  // Called in the IDLE cycle where req is seen; returns in the following IDLE cycle.
  task automatic expect_window(input int own, input int ln, input bit tamper);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[own] = 1'b1;
    step();
    check("clr_gnt", 32'(gnt), 32'(oh));
    check("clr_pulse", 32'(cnt_clr), 32'd1);
    check("clr_en", 32'(cnt_en), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    if (tamper) begin
      req[own] = 1'b0;
      len[own*W +: W] = W'(ln + 7);
    end
    for (int i = 0; i <= ln; i++) begin
      step();
      check("run_gnt", 32'(gnt), 32'(oh));
      check("run_en", 32'(cnt_en), 32'(i < ln));
      check("run_cnt", 32'(cnt_q), 32'(i));
    end
    step();
    check("done_pulse", 32'(done), 32'(oh));
    check("done_gnt", 32'(gnt), 32'd0);
    check("done_aborted", 32'(aborted), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    // reset state
    step();
    step();
    mon_en = 1'b1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_clr", 32'(cnt_clr), 32'd0);
    check("rst_en", 32'(cnt_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step();

    // single window, requester 0, len 5
    req = 4'b0001;
    len[0 +: W] = 8'd5;
    expect_window(0, 5, 1'b0);
    req = '0;

    // full round robin after a fresh reset, all len 2
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    len = {4{8'd2}};
    req = 4'b1111;
    expect_window(0, 2, 1'b0);
    expect_window(1, 2, 1'b0);
    expect_window(2, 2, 1'b0);
    expect_window(3, 2, 1'b0);
    expect_window(0, 2, 1'b0);
    req = '0;

    // abort mid-run of requester 2 at cnt_q=10
    req = 4'b0100;
    len[2*W +: W] = 8'd200;
    step();
    check("abt_gnt", 32'(gnt), 32'b0100);
    req = '0;
    for (int i = 0; i <= 10; i++) step();
    check("abt_cnt10", 32'(cnt_q), 32'd10);
    check("abt_en_before", 32'(cnt_en), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_done", 32'(done), 32'b0100);
    check("abt_flag", 32'(aborted), 32'd1);
    check("abt_en_after", 32'(cnt_en), 32'd0);
    check("abt_cnt11", 32'(cnt_q), 32'd11);
    step();
    check("abt_done_width", 32'(done), 32'd0);
    check("abt_flag_width", 32'(aborted), 32'd0);
    check("abt_cnt_hold", 32'(cnt_q), 32'd11);
    check("abt_idle", 32'(busy), 32'd0);

    // zero-length window for requester 1
    req = 4'b0010;
    len[1*W +: W] = 8'd0;
    expect_window(1, 0, 1'b0);
    req = '0;

    // reset mid-run of requester 3, then requester 0 wins first
    req = 4'b1000;
    len[3*W +: W] = 8'd50;
    step();
    check("r3_gnt", 32'(gnt), 32'b1000);
    req = '0;
    step();
    step();
    step();
    check("r3_run_en", 32'(cnt_en), 32'd1);
    reset = 1'b0;
    step();
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_clr", 32'(cnt_clr), 32'd0);
    check("midrst_en", 32'(cnt_en), 32'd0);
    check("midrst_aborted", 32'(aborted), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    req = 4'b1001;
    expect_window(0, 2, 1'b0);
    req = '0;

    // len change and req drop during the window do not affect it
    req = 4'b0010;
    len[1*W +: W] = 8'd3;
    expect_window(1, 3, 1'b1);
    req = '0;
    step();
    check("final_idle", 32'(busy), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
